// File: rtl/reset_sel_pkg.sv
// reset_sel_pkg: shared state encoding and default dwell settings for the
// reset-select sequencer.
package reset_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PRE    = 2'b01,
    STROBE = 2'b10,
    POST   = 2'b11
  } reset_sel_state_t;

  localparam int DEF_PRE_CYCLES  = 4;
  localparam int DEF_POST_CYCLES = 8;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/reset_sel_dwell_cnt.sv
// reset_sel_dwell_cnt: loadable down-counter with zero flag, shared by the
// pre-hold and post-hold windows of the sequencer.
module reset_sel_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] LOAD_VAL,
  input  logic             DEC,
  output logic             ZERO
);

  logic [CNT_W-1:0] count;

  // Load takes priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (LOAD) begin
      count <= LOAD_VAL;
    end else if (DEC && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign ZERO = (count == '0);

endmodule

// File: rtl/reset_sel_sequencer.sv
// reset_sel_sequencer: drives SELECT / SELECT_ENABLE of the two-input reset
// mux, holding the downstream reset across each source change
// (pre-hold, one-cycle strobe, post-hold).
// Optional build macro RESET_SEL_INIT_STROBE_EN: run one automatic switch to
// source B (target 0) after reset so the unreset mux selector is known.
module reset_sel_sequencer
  import reset_sel_pkg::*;
#(
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int POST_CYCLES = DEF_POST_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  output logic SELECT,
  output logic SELECT_ENABLE,
  output logic HOLD_RST,
  output logic CUR_SEL,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_CYCLES - 1);

  reset_sel_state_t state, state_d;
  logic             target_q, target_d;
  logic             select_q, select_d;
  logic             sel_en_q, sel_en_d;
  logic             hold_q, hold_d;
  logic             cur_q, cur_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             idle_ready;
  logic             accept;

`ifdef RESET_SEL_INIT_STROBE_EN
  logic init_pending;
  logic init_clr;

  // Pending flag for the automatic post-reset sequence; set by reset, cleared
  // once that sequence has been launched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_pending <= 1'b1;
    end else if (init_clr) begin
      init_pending <= 1'b0;
    end
  end

  assign idle_ready = (state == IDLE) && !init_pending;
`else
  assign idle_ready = (state == IDLE);
`endif

  assign REQ_READY = idle_ready;
  assign accept    = REQ_VALID && idle_ready;

  reset_sel_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (cnt_load),
    .LOAD_VAL (cnt_load_val),
    .DEC      (cnt_dec),
    .ZERO     (cnt_zero)
  );

  // State and registered mux-facing outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      target_q <= 1'b0;
      select_q <= 1'b0;
      sel_en_q <= 1'b0;
      hold_q   <= 1'b0;
      cur_q    <= 1'b0;
    end else begin
      state    <= state_d;
      target_q <= target_d;
      select_q <= select_d;
      sel_en_q <= sel_en_d;
      hold_q   <= hold_d;
      cur_q    <= cur_d;
    end
  end

  // Next-state, next-output and dwell counter control.
  always_comb begin
    state_d      = state;
    target_d     = target_q;
    select_d     = select_q;
    sel_en_d     = 1'b0;
    hold_d       = hold_q;
    cur_d        = cur_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
`ifdef RESET_SEL_INIT_STROBE_EN
    init_clr     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef RESET_SEL_INIT_STROBE_EN
        if (init_pending) begin
          init_clr     = 1'b1;
          target_d     = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
          hold_d       = 1'b1;
          state_d      = PRE;
        end else
`endif
        // A redundant request is consumed here without leaving IDLE.
        if (accept && (REQ_SEL != cur_q)) begin
          target_d     = REQ_SEL;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
          hold_d       = 1'b1;
          state_d      = PRE;
        end
      end
      PRE: begin
        hold_d = 1'b1;
        if (cnt_zero) begin
          select_d = target_q;
          sel_en_d = 1'b1;
          state_d  = STROBE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STROBE: begin
        hold_d       = 1'b1;
        cur_d        = target_q;
        cnt_load     = 1'b1;
        cnt_load_val = POST_LOAD;
        state_d      = POST;
      end
      POST: begin
        hold_d = 1'b1;
        if (cnt_zero) begin
          hold_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        hold_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign SELECT        = select_q;
  assign SELECT_ENABLE = sel_en_q;
  assign HOLD_RST      = hold_q;
  assign CUR_SEL       = cur_q;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_reset_sel_sequencer.sv
// tb_reset_sel_sequencer: two sequencer instances (default dwell and 1/1
// dwell) driven with directed and random switch requests, checked against a
// cycle-offset model of the switch timeline.
module tb_reset_sel_sequencer;

  localparam int A_PRE  = 4;
  localparam int A_POST = 8;
  localparam int B_PRE  = 1;
  localparam int B_POST = 1;
`ifdef RESET_SEL_INIT_STROBE_EN
  localparam logic READY_IN_RST = 1'b0;
`else
  localparam logic READY_IN_RST = 1'b1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic a_valid = 1'b0, a_sel = 1'b0;
  logic a_ready, a_select, a_en, a_hold, a_cur, a_busy;
  logic b_valid = 1'b0, b_sel = 1'b0;
  logic b_ready, b_select, b_en, b_hold, b_cur, b_busy;

  int tests = 0;
  int fails = 0;

  // Model of each instance: committed selection and mux selector value.
  bit m_cur [2];
  bit m_sel [2];

  always #5 CLK = ~CLK;

  reset_sel_sequencer #(
    .PRE_CYCLES  (A_PRE),
    .POST_CYCLES (A_POST),
    .CNT_W       (8)
  ) dut_a (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_VALID     (a_valid),
    .REQ_SEL       (a_sel),
    .REQ_READY     (a_ready),
    .SELECT        (a_select),
    .SELECT_ENABLE (a_en),
    .HOLD_RST      (a_hold),
    .CUR_SEL       (a_cur),
    .BUSY          (a_busy)
  );

  reset_sel_sequencer #(
    .PRE_CYCLES  (B_PRE),
    .POST_CYCLES (B_POST),
    .CNT_W       (4)
  ) dut_b (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_VALID     (b_valid),
    .REQ_SEL       (b_sel),
    .REQ_READY     (b_ready),
    .SELECT        (b_select),
    .SELECT_ENABLE (b_en),
    .HOLD_RST      (b_hold),
    .CUR_SEL       (b_cur),
    .BUSY          (b_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input int which, input logic exp_ready);
    if (which == 0) begin
      chk("rst ready A", a_ready, exp_ready);  chk("rst select A", a_select, 1'b0);
      chk("rst en A", a_en, 1'b0);             chk("rst hold A", a_hold, 1'b0);
      chk("rst cur A", a_cur, 1'b0);           chk("rst busy A", a_busy, 1'b0);
    end else begin
      chk("rst ready B", b_ready, exp_ready);  chk("rst select B", b_select, 1'b0);
      chk("rst en B", b_en, 1'b0);             chk("rst hold B", b_hold, 1'b0);
      chk("rst cur B", b_cur, 1'b0);           chk("rst busy B", b_busy, 1'b0);
    end
  endtask

  // Expected outputs t cycles after the accept edge of a switch spanning
  // `span` busy cycles (span 0 = redundant request).
  task automatic expect_cycle(input int which, input int t, input int span,
                              input int pre, input bit tgt);
    logic r, s, e, h, c, b;
    bit in_seq, sw;
    sw     = (span > 0);
    in_seq = sw && (t <= span);
    if (which == 0) begin
      r = a_ready; s = a_select; e = a_en; h = a_hold; c = a_cur; b = a_busy;
    end else begin
      r = b_ready; s = b_select; e = b_en; h = b_hold; c = b_cur; b = b_busy;
    end
    chk($sformatf("ready[%0d] t=%0d", which, t), r, !in_seq);
    chk($sformatf("busy[%0d] t=%0d", which, t), b, in_seq);
    chk($sformatf("hold[%0d] t=%0d", which, t), h, in_seq);
    chk($sformatf("strobe[%0d] t=%0d", which, t), e, sw && (t == pre + 1));
    chk($sformatf("select[%0d] t=%0d", which, t), s,
        (sw && t >= pre + 1) ? tgt : m_sel[which]);
    chk($sformatf("cur_sel[%0d] t=%0d", which, t), c,
        (sw && t >= pre + 2) ? tgt : m_cur[which]);
  endtask

  // Called just after the accept edge; returns in the first IDLE cycle.
  task automatic follow(input int which, input bit tgt, input bit chain);
    int pre, post, span;
    pre  = (which == 0) ? A_PRE : B_PRE;
    post = (which == 0) ? A_POST : B_POST;
    span = (tgt == m_cur[which]) ? 0 : pre + 1 + post;
    for (int t = 1; t <= span + 1; t++) begin
      expect_cycle(which, t, span, pre, tgt);
      if (chain && t == pre + 3) begin
        a_valid = 1'b1;
        a_sel   = ~tgt;
      end
      if (t <= span) begin
        @(posedge CLK); #1;
      end
    end
    m_cur[which] = tgt;
    if (span > 0) m_sel[which] = tgt;
  endtask

  task automatic issue(input int which, input bit tgt, input bit chain);
    if (which == 0) begin a_valid = 1'b1; a_sel = tgt; end
    else            begin b_valid = 1'b1; b_sel = tgt; end
    @(posedge CLK); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    follow(which, tgt, chain);
    if (chain) begin
      // Request raised during POST is taken on the first IDLE edge.
      @(posedge CLK); #1;
      a_valid = 1'b0;
      follow(0, ~tgt, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      chk("idle ready A", a_ready, 1'b1);
      chk("idle hold B", b_hold, 1'b0);
    end
  endtask

  task automatic wait_init();
`ifdef RESET_SEL_INIT_STROBE_EN
    int hc, ec;
    hc = 0;
    ec = 0;
    for (int i = 0; i < 60 && !(a_ready && b_ready); i++) begin
      @(posedge CLK); #1;
      if (a_hold) hc++;
      if (a_en) begin
        ec++;
        chk("init select A", a_select, 1'b0);
      end
    end
    chk("init ready", a_ready && b_ready, 1'b1);
    chk("init hold length A", hc == A_PRE + 1 + A_POST, 1'b1);
    chk("init strobe count A", ec == 1, 1'b1);
`endif
  endtask

  initial begin
    bit tgt, chain;
    int which, ec;

    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals(0, READY_IN_RST);
    chk_reset_vals(1, READY_IN_RST);
    RST = 1'b0;
    wait_init();
    chk_reset_vals(0, 1'b1);

    // Directed: full switch, redundant, switch with a request held in POST.
    issue(0, 1'b1, 1'b0);
    issue(0, 1'b1, 1'b0);
    issue(0, 1'b0, 1'b1);
    idle_cycles(2);
    // Minimal dwell instance.
    issue(1, 1'b1, 1'b0);
    issue(1, 1'b0, 1'b0);
    issue(1, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      which = int'($urandom % 2);
      tgt   = 1'($urandom % 2);
      chain = (which == 0) && (tgt != m_cur[0]) && ($urandom % 3 == 0);
      issue(which, tgt, chain);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // Reset in the third PRE cycle.
    tgt = ~m_cur[0];
    a_valid = 1'b1;
    a_sel   = tgt;
    @(posedge CLK); #1;
    a_valid = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("pre hold before reset", a_hold, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk_reset_vals(0, READY_IN_RST);
    chk_reset_vals(1, READY_IN_RST);
    @(posedge CLK); #1;
    RST = 1'b0;
    m_cur = '{1'b0, 1'b0};
    m_sel = '{1'b0, 1'b0};
`ifdef RESET_SEL_INIT_STROBE_EN
    wait_init();
`else
    ec = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      if (a_en || b_en) ec++;
    end
    chk("no strobe after reset", ec == 0, 1'b1);
    chk_reset_vals(0, 1'b1);
`endif
    issue(0, 1'b1, 1'b0);
    issue(1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_sel_sequencer.md
# reset_sel_sequencer

- Upstream control stage for the two-input reset multiplexer: produces that mux's `SELECT` / `SELECT_ENABLE` pair.
- Sequences every source change so downstream logic is held in reset across the switch:
  - a pre-hold window;
  - a one-cycle select-enable strobe;
  - a post-hold window.
- Requests arrive over a valid/ready handshake from the clock/reset control fabric.
- Tracks the committed selection so redundant requests complete immediately.

## Interface
Parameters:
- PRE_CYCLES, 4, hold cycles before the strobe; legal range 1..2^CNT_W-1
- POST_CYCLES, 8, hold cycles after the strobe; legal range 1..2^CNT_W-1
- CNT_W, 8, dwell counter width

Ports:
- CLK  in  1  sole clock; all state updates on posedge
- RST  in  1  reset; asynchronous, active-high (fixed)
- REQ_VALID  in  1  switch request present
- REQ_SEL  in  1  requested source: 1 = A, 0 = B
- REQ_READY  out  1  request may be accepted this cycle
- SELECT  out  1  selector value to the mux, registered
- SELECT_ENABLE  out  1  one-cycle strobe telling the mux to load SELECT, registered
- HOLD_RST  out  1  active-high reset to be ORed into the downstream reset, registered
- CUR_SEL  out  1  committed selection, registered
- BUSY  out  1  sequence in progress, i.e. state != IDLE

## Operation
- States: IDLE, PRE, STROBE, POST.
- Reset values (async on RST high):
  - state = IDLE;
  - SELECT = 0, SELECT_ENABLE = 0, HOLD_RST = 0, CUR_SEL = 0, counter = 0.
- REQ_READY = (state == IDLE). Accept = REQ_VALID & REQ_READY.
- IDLE, on accept:
  - if REQ_SEL == CUR_SEL: request consumed, state stays IDLE, no outputs change;
  - otherwise: latch target = REQ_SEL, load counter with PRE_CYCLES-1, assert HOLD_RST, go to PRE.
- PRE:
  - HOLD_RST = 1;
  - decrement counter; at 0, go to STROBE with SELECT = target and SELECT_ENABLE = 1.
- STROBE:
  - lasts exactly one cycle with SELECT_ENABLE = 1 and HOLD_RST = 1;
  - CUR_SEL <= target;
  - load counter with POST_CYCLES-1, go to POST, SELECT_ENABLE <= 0.
- POST:
  - HOLD_RST = 1;
  - decrement counter; at 0, go to IDLE and HOLD_RST <= 0.
- SELECT holds its last value outside STROBE. It changes only on entry to STROBE.
- Requests presented while BUSY are not accepted. REQ_VALID must be held by the requester until accepted.
- Counter arithmetic is unsigned CNT_W bits, decrement only. It never wraps, because the exit condition is a compare to 0.
- Reset mid-sequence:
  - state returns to IDLE immediately and HOLD_RST drops;
  - the mux's selector register is not reset and may disagree with CUR_SEL = 0 (see Configuration).

## Timing
- Accept on edge k; HOLD_RST high from cycle k+1.
- PRE occupies cycles k+1 .. k+PRE_CYCLES.
- STROBE occupies cycle k+PRE_CYCLES+1. The mux samples on the edge ending that cycle, and its output changes in the first POST cycle.
- POST occupies the next POST_CYCLES cycles.
- REQ_READY rises in cycle k+PRE_CYCLES+POST_CYCLES+2.
- Total BUSY = PRE_CYCLES+1+POST_CYCLES cycles.
- Redundant request: zero busy cycles; REQ_READY stays 1.
- Back-to-back: the earliest next accept is the first IDLE cycle.

## Configuration
- RESET_SEL_INIT_STROBE_EN
  - Defined: after RST deasserts, the FSM runs one automatic PRE/STROBE/POST sequence with target 0 before REQ_READY first rises. This forces the mux's unreset selector to a known state. HOLD_RST is high throughout.
  - Undefined: the FSM enters IDLE directly; the mux selector state after reset is whatever its own initialisation gives.

## Structure
- Shared package reset_sel_pkg holds:
  - state typedef with encoding IDLE=2'b00, PRE=2'b01, STROBE=2'b10, POST=2'b11;
  - default PRE_CYCLES / POST_CYCLES / CNT_W constants.
- One sub-module is natural: reset_sel_dwell_cnt, a loadable down-counter with a zero flag, instanced once and shared by PRE and POST.

## Test plan
- Reset with defaults → all outputs 0, REQ_READY = 1. With the macro defined: HOLD_RST high 13 cycles, one SELECT_ENABLE pulse with SELECT = 0, then REQ_READY = 1.
- REQ_SEL = 1 accepted at edge k → HOLD_RST high for 13 cycles, SELECT_ENABLE high only in cycle k+5 with SELECT = 1, CUR_SEL = 1 from k+6, REQ_READY high at k+14.
- REQ_SEL equal to CUR_SEL → accepted in one cycle; SELECT_ENABLE and HOLD_RST never assert.
- REQ_VALID held during POST with a new target → not accepted until IDLE, then a second full sequence runs.
- RST asserted in cycle 3 of PRE → all outputs return to reset values asynchronously; no SELECT_ENABLE pulse is emitted.
- PRE_CYCLES = 1, POST_CYCLES = 1 → BUSY exactly 3 cycles; strobe in the second of them.
